// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and width for the iterative divider
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   partial_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // When the subtract succeeds the true difference is below the divisor,
    // so the low WIDTH bits of the truncated subtraction are exact.
    always_comb begin
        q_bit_o = (partial_i >= {1'b0, divisor_i});
        rem_o   = q_bit_o ? (partial_i[WIDTH-1:0] - divisor_i) : partial_i[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer returning {remainder, quotient}
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic               qneg_q;
    logic               rneg_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic               q_bit;

    assign op1_abs = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign op2_abs = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .partial_i ({rem_q, dvd_q[WIDTH-1]}),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit)
    );

    assign quo_d = {quo_q[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else if (annul) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (opdata2 == '0) begin
                            result_q <= '0;
                            state_q  <= DIV_DONE;
                        end else begin
                            dvd_q   <= op1_abs;
                            dvs_q   <= op2_abs;
                            rem_q   <= '0;
                            quo_q   <= '0;
                            qneg_q  <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                            rneg_q  <= signed_div & opdata1[WIDTH-1];
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The last step's outputs feed the fix-up directly, saving a cycle.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_q <= {(rneg_q ? -rem_d : rem_d), (qneg_q ? -quo_d : quo_d)};
                        state_q  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (!start) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign ready  = (state_q == DIV_DONE);
    assign busy   = (state_q == DIV_BUSY);

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq with an expected-result queue
module tb_div_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    div_seq dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        ma = (s && a[31]) ? (32'd0 - a) : a;
        mb = (s && b[31]) ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[31] ^ b[31])) q = 32'd0 - q;
        if (s && a[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Raises start at a falling edge, then counts falling edges until ready.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output int busy_cycles, output logic [63:0] res,
                         output logic timed_out);
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        lat = 0;
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (ready) begin
                lat = i;
                timed_out = 1'b0;
                break;
            end
        end
        res = result;
        // Scramble operands to show they are ignored once accepted.
        opdata1 = $urandom;
        opdata2 = $urandom;
    endtask

    task automatic finish_op();
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = 32'd0; opdata2 = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int lat, bc; logic [63:0] res, exp; logic to;
        sb_q.push_back({32'h0000_0002, 32'h0000_000E});
        do_op(32'd100, 32'd7, 1'b0, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || lat != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        checks++; if (bc != 32) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=32", bc); end
        checks++; if (res !== exp) begin failures++; $display("FAIL divu_result got=%h exp=%h", res, exp); end
        finish_op();
    endtask

    task automatic test_signed();
        int lat, bc; logic [63:0] res, exp; logic to;
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(32'hFFFF_FFF9, 32'h2, 1'b1, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL div_signed got=%h exp=%h", res, exp); end
        finish_op();
        sb_q.push_back({32'h0000_0001, 32'h7FFF_FFFC});
        do_op(32'hFFFF_FFF9, 32'h2, 1'b0, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL divu_same_ops got=%h exp=%h", res, exp); end
        finish_op();
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        do_op(32'hFFFF_FFE7, 32'h4, 1'b1, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL div_neg_dividend got=%h exp=%h", res, exp); end
        finish_op();
        sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFA});
        do_op(32'd25, 32'hFFFF_FFFC, 1'b1, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL div_neg_divisor got=%h exp=%h", res, exp); end
        finish_op();
    endtask

    task automatic test_div_zero();
        int lat, bc; logic [63:0] res, exp; logic to;
        sb_q.push_back(64'd0);
        do_op(32'd1234, 32'd0, 1'b1, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || lat != 1) begin failures++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
        checks++; if (bc != 0) begin failures++; $display("FAIL divzero_busy got=%0d exp=0", bc); end
        checks++; if (res !== exp) begin failures++; $display("FAIL divzero_result got=%h exp=%h", res, exp); end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat, bc; logic [63:0] res, exp; logic to;
        sb_q.push_back({32'h0000_0000, 32'h8000_0000});
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL overflow got=%h exp=%h", res, exp); end
        finish_op();
    endtask

    task automatic test_handshake();
        int lat, bc; logic [63:0] res, exp; logic to;
        sb_q.push_back({32'd4, 32'd5});
        do_op(32'd49, 32'd9, 1'b0, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || res !== exp) begin failures++; $display("FAIL hold_result got=%h exp=%h", res, exp); end
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b exp=1", ready); end
        checks++; if (result !== exp) begin failures++; $display("FAIL hold_stable got=%h exp=%h", result, exp); end
        start = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", ready); end
    endtask

    task automatic test_annul();
        int lat, bc; logic [63:0] res, exp, prev; logic to;
        prev = result;
        @(negedge clk);
        opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL annul_busy_before got=%b exp=1", busy); end
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL annul_idle got=busy%b/ready%b exp=0/0", busy, ready); end
        checks++; if (result !== prev) begin failures++; $display("FAIL annul_result got=%h exp=%h", result, prev); end
        repeat (40) @(negedge clk);
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL annul_no_ready got=%b exp=0", ready); end
        sb_q.push_back({32'd0, 32'd3});
        do_op(32'd9, 32'd3, 1'b0, lat, bc, res, to);
        exp = sb_q.pop_front();
        checks++; if (to || lat != 33) begin failures++; $display("FAIL after_annul_latency got=%0d exp=33", lat); end
        checks++; if (res !== exp) begin failures++; $display("FAIL after_annul_result got=%h exp=%h", res, exp); end
        finish_op();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
        repeat (5) @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        checks++; if (result !== 64'd0 || ready !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid got=%h/%b/%b exp=0/0/0", result, ready, busy);
        end
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [63:0] res, exp; logic to;
        logic [31:0] a, b; logic s;
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            b = (n == 3) ? 32'd0 : ((n % 2 == 0) ? $urandom : $urandom_range(1, 1000));
            s = n[0];
            sb_q.push_back(model_div(a, b, s));
            do_op(a, b, s, lat, bc, res, to);
            exp = sb_q.pop_front();
            checks++; if (to || lat != ((b == 32'd0) ? 1 : 33)) begin failures++; $display("FAIL b2b_latency n=%0d got=%0d", n, lat); end
            checks++; if (res !== exp) begin failures++; $display("FAIL b2b_result n=%0d a=%h b=%h s=%b got=%h exp=%h", n, a, b, s, res, exp); end
            finish_op();
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_handshake();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
